// File: rtl/spi_slave_sync.sv
// SPI slave fully in the system clock domain: synchronised SCK/CS/MOSI, all four SPI modes, back-to-back words per CS.
// Define SPI_SLAVE_LSB_FIRST_EN to shift both directions LSB-first (default build is MSB-first).
module spi_slave_sync #(
  parameter int WIDTH       = 32,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ack,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  FULL = CW'(WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
  logic                   sck_hist, cs_hist;
  logic [SYNC_STAGES:0]   prime;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_sr   <= {SYNC_STAGES{CPOL}};
      cs_sr    <= '1;
      mosi_sr  <= '0;
      sck_hist <= CPOL;
      cs_hist  <= 1'b1;
      prime    <= '0;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      sck_hist <= sck_sr[SYNC_STAGES-1];
      cs_hist  <= cs_sr[SYNC_STAGES-1];
      prime    <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic lead, trail, sample_edge, shift_edge, cs_fall, cs_rise;

  assign sck_s  = sck_sr[SYNC_STAGES-1];
  assign cs_s   = cs_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  assign lead        = (sck_hist == CPOL) && (sck_s != CPOL);
  assign trail       = (sck_hist != CPOL) && (sck_s == CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead  : trail;
  // A fall only counts once the pipeline holds post-reset pin values, so a CS
  // already low at reset release must first go high before a frame can start.
  assign cs_fall     = prime[SYNC_STAGES] && cs_hist && !cs_s;
  assign cs_rise     = !cs_hist && cs_s;

  state_t           state, state_nx;
  logic [WIDTH-1:0] tx_shift, tx_nx, tx_adv;
  logic [WIDTH-1:0] rx_shift, rx_nx, rx_adv;
  logic [WIDTH-1:0] rxd_nx;
  logic [CW-1:0]    bit_cnt, cnt_nx;
  logic             rxv_nx, ack_nx, ferr_nx;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign spi_miso = tx_shift[0];
  assign tx_adv   = {1'b0, tx_shift[WIDTH-1:1]};
  assign rx_adv   = {mosi_s, rx_shift[WIDTH-1:1]};
`else
  assign spi_miso = tx_shift[WIDTH-1];
  assign tx_adv   = {tx_shift[WIDTH-2:0], 1'b0};
  assign rx_adv   = {rx_shift[WIDTH-2:0], mosi_s};
`endif

  assign busy        = (state == ACTIVE);
  assign spi_miso_oe = busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_ack    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      tx_shift  <= tx_nx;
      rx_shift  <= rx_nx;
      bit_cnt   <= cnt_nx;
      rx_data   <= rxd_nx;
      rx_valid  <= rxv_nx;
      tx_ack    <= ack_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tx_nx    = tx_shift;
    rx_nx    = rx_shift;
    cnt_nx   = bit_cnt;
    rxd_nx   = rx_data;
    rxv_nx   = 1'b0;
    ack_nx   = 1'b0;
    ferr_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nx = ACTIVE;
          tx_nx    = tx_data;
          ack_nx   = 1'b1;
          cnt_nx   = '0;
        end
      end
      ACTIVE: begin
        if (bit_cnt == FULL) begin
          // word complete: publish and reload for a back-to-back word
          rxd_nx = rx_shift;
          rxv_nx = 1'b1;
          cnt_nx = '0;
          if (cs_rise) begin
            state_nx = IDLE;
          end else begin
            tx_nx  = tx_data;
            ack_nx = 1'b1;
          end
        end else begin
          if (sample_edge) begin
            rx_nx  = rx_adv;
            cnt_nx = bit_cnt + CW'(1);
          end
          // the shift edge preceding the first sample of a word must not move the MSB
          if (shift_edge && bit_cnt != '0) tx_nx = tx_adv;
          if (cs_rise) begin
            state_nx = IDLE;
            if (cnt_nx == FULL) begin
              rxd_nx = rx_nx;
              rxv_nx = 1'b1;
            end else if (cnt_nx != '0) begin
              ferr_nx = 1'b1;
            end
            cnt_nx = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: one W32 mode-0 slave, W16 slaves in modes 1..3 and a W8 mode-0 slave
// share a bus-functional SPI master; received words are scoreboarded against an expected queue.
module tb_spi_slave_sync;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mosi = 1'b0;
  logic sck [5];
  logic cs_n [5];
  logic miso [5];
  logic oe [5];
  logic ack [5];
  logic rxv [5];
  logic ferr [5];
  logic busy [5];
  logic [63:0] txd [5];
  logic [63:0] rxd [5];
  logic [31:0] rx32;
  logic [15:0] rx16 [1:3];
  logic [7:0]  rx8;

  always #5 clk = ~clk;

  spi_slave_sync #(.WIDTH(32), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .clk(clk), .reset_n(reset_n), .spi_sck(sck[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi),
    .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .tx_data(txd[0][31:0]), .tx_ack(ack[0]),
    .rx_data(rx32), .rx_valid(rxv[0]), .frame_err(ferr[0]), .busy(busy[0]));
  assign rxd[0] = {32'd0, rx32};

  for (genvar m = 1; m < 4; m++) begin : g_w16
    spi_slave_sync #(.WIDTH(16), .CPOL(bit'(m / 2)), .CPHA(bit'(m % 2))) u_dut (
      .clk(clk), .reset_n(reset_n), .spi_sck(sck[m]), .spi_cs_n(cs_n[m]), .spi_mosi(mosi),
      .spi_miso(miso[m]), .spi_miso_oe(oe[m]), .tx_data(txd[m][15:0]), .tx_ack(ack[m]),
      .rx_data(rx16[m]), .rx_valid(rxv[m]), .frame_err(ferr[m]), .busy(busy[m]));
    assign rxd[m] = {48'd0, rx16[m]};
  end

  spi_slave_sync #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_w8 (
    .clk(clk), .reset_n(reset_n), .spi_sck(sck[4]), .spi_cs_n(cs_n[4]), .spi_mosi(mosi),
    .spi_miso(miso[4]), .spi_miso_oe(oe[4]), .tx_data(txd[4][7:0]), .tx_ack(ack[4]),
    .rx_data(rx8), .rx_valid(rxv[4]), .frame_err(ferr[4]), .busy(busy[4]));
  assign rxd[4] = {56'd0, rx8};

  // Monitor: records every rx_valid and counts handshake pulses
  int          obs_n = 0;
  int          obs_id [64];
  logic [63:0] obs_d [64];
  int          ack_cnt [5]    = '{0, 0, 0, 0, 0};
  int          ferr_pulse [5] = '{0, 0, 0, 0, 0};
  int          ferr_cyc [5]   = '{0, 0, 0, 0, 0};
  logic        ferr_prev [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rxv[i] === 1'b1 && obs_n < 64) begin
        obs_id[obs_n] = i;
        obs_d[obs_n]  = rxd[i];
        obs_n++;
      end
      if (ack[i] === 1'b1) ack_cnt[i]++;
      if (ferr[i] === 1'b1) ferr_cyc[i]++;
      if (ferr[i] === 1'b1 && ferr_prev[i] !== 1'b1) ferr_pulse[i]++;
      ferr_prev[i] = ferr[i];
    end
  end

  typedef struct packed { logic [7:0] id; logic [63:0] d; } exp_t;
  exp_t exp_q [$];
  int   obs_rd = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic int width_of(input int id);
    return (id == 0) ? 32 : (id == 4) ? 8 : 16;
  endfunction
  function automatic bit cpol_of(input int id);
    return (id == 2 || id == 3);
  endfunction
  function automatic bit cpha_of(input int id);
    return (id == 1 || id == 3);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " rx_valid seen"}, 64'(obs_n > obs_rd), 64'd1);
      if (obs_n > obs_rd) begin
        chk({tag, " rx id"}, 64'(obs_id[obs_rd]), 64'(e.id));
        chk({tag, " rx_data"}, obs_d[obs_rd], e.d);
        obs_rd++;
      end
    end
    chk({tag, " extra rx_valid"}, 64'(obs_n - obs_rd), 64'd0);
    obs_rd = obs_n;
  endtask

  // Bus-functional master: SCK at clk/8, pins driven on the falling clk edge.
  // fast_end raises CS together with the final sample edge.
  task automatic word(input int id, input logic [63:0] tx, input int nbits, input bit fast_end,
                      output logic [63:0] rx, output logic first);
    int w, b;
    bit cpol, cpha;
    w = width_of(id);
    cpol = cpol_of(id);
    cpha = cpha_of(id);
    rx = '0;
    first = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = LSB ? i : w - 1 - i;
      if (!cpha) begin
        mosi = tx[b];
        wclk(4);
        rx[b] = miso[id];
        if (i == 0) first = miso[id];
        sck[id] = ~cpol;
        if (fast_end && i == nbits - 1) cs_n[id] = 1'b1;
        wclk(4);
        sck[id] = cpol;
      end else begin
        wclk(4);
        sck[id] = ~cpol;
        mosi = tx[b];
        wclk(4);
        rx[b] = miso[id];
        if (i == 0) first = miso[id];
        sck[id] = cpol;
        if (fast_end && i == nbits - 1) cs_n[id] = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r, r3 [3];
    logic        f;
    int          a0, fp0, fc0;

    for (int i = 0; i < 5; i++) begin
      sck[i]  = cpol_of(i);
      cs_n[i] = 1'b1;
      txd[i]  = '0;
    end
    reset_n = 1'b0;
    wclk(3);
    chk("reset rx_data", rxd[0], 64'd0);
    chk("reset rx_valid", 64'(rxv[0]), 64'd0);
    chk("reset tx_ack", 64'(ack[0]), 64'd0);
    chk("reset frame_err", 64'(ferr[0]), 64'd0);
    chk("reset busy", 64'(busy[0]), 64'd0);
    chk("reset miso_oe", 64'(oe[0]), 64'd0);
    chk("reset miso", 64'(miso[0]), 64'd0);
    reset_n = 1'b1;
    wclk(8);

    // mode 0, 32-bit single word
    txd[0] = 64'hA5A5_0F0F;
    a0 = ack_cnt[0];
    fp0 = ferr_pulse[0];
    cs_n[0] = 1'b0;
    exp_q.push_back('{8'd0, 64'h1234_5678});
    wclk(4);
    chk("m0 tx_ack at cs fall", 64'(ack_cnt[0] - a0), 64'd1);
    chk("m0 busy", 64'(busy[0]), 64'd1);
    chk("m0 miso_oe", 64'(oe[0]), 64'd1);
    word(0, 64'h1234_5678, 32, 1'b0, r, f);
    wclk(4);
    cs_n[0] = 1'b1;
    wclk(10);
    sb_check("m0");
    chk("m0 master read", r, 64'hA5A5_0F0F);
    chk("m0 clean end frame_err", 64'(ferr_pulse[0] - fp0), 64'd0);
    chk("m0 busy after cs", 64'(busy[0]), 64'd0);

    // modes 1..3, 16-bit; mode 3 ends with CS rising on the final sample edge
    for (int m = 1; m < 4; m++) begin
      txd[m] = 64'h5AA5;
      fp0 = ferr_pulse[m];
      cs_n[m] = 1'b0;
      exp_q.push_back('{8'(m), 64'hBEEF});
      word(m, 64'hBEEF, 16, m == 3, r, f);
      if (m != 3) begin
        wclk(4);
        cs_n[m] = 1'b1;
      end
      wclk(10);
      sb_check($sformatf("mode%0d", m));
      chk($sformatf("mode%0d master read", m), r, 64'h5AA5);
      chk($sformatf("mode%0d frame_err", m), 64'(ferr_pulse[m] - fp0), 64'd0);
    end

    // three back-to-back words in one CS assertion
    txd[0] = 64'h10;
    a0 = ack_cnt[0];
    fp0 = ferr_pulse[0];
    cs_n[0] = 1'b0;
    exp_q.push_back('{8'd0, 64'h1});
    exp_q.push_back('{8'd0, 64'h2});
    exp_q.push_back('{8'd0, 64'h3});
    fork
      begin
        for (int k = 0; k < 3; k++) word(0, 64'(k + 1), 32, k == 2, r3[k], f);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          bit seen;
          int t;
          seen = 1'b0;
          t = 0;
          while (t < 2000 && !seen) begin
            @(negedge clk);
            if (ack[0] === 1'b1) seen = 1'b1;
            t++;
          end
          chk("b2b tx_ack within budget", 64'(seen), 64'd1);
          txd[0] = (k == 0) ? 64'h20 : 64'h30;
        end
      end
    join
    wclk(10);
    sb_check("b2b");
    chk("b2b read0", r3[0], 64'h10);
    chk("b2b read1", r3[1], 64'h20);
    chk("b2b read2", r3[2], 64'h30);
    chk("b2b tx_ack count", 64'(ack_cnt[0] - a0), 64'd3);
    chk("b2b frame_err", 64'(ferr_pulse[0] - fp0), 64'd0);

    // restore rx_data to a known word, then abort after 13 bits
    cs_n[0] = 1'b0;
    exp_q.push_back('{8'd0, 64'h1234_5678});
    word(0, 64'h1234_5678, 32, 1'b0, r, f);
    wclk(4);
    cs_n[0] = 1'b1;
    wclk(10);
    sb_check("pre-abort");
    fp0 = ferr_pulse[0];
    fc0 = ferr_cyc[0];
    cs_n[0] = 1'b0;
    word(0, 64'hFFFF_FFFF, 13, 1'b0, r, f);
    wclk(4);
    cs_n[0] = 1'b1;
    wclk(10);
    chk("abort frame_err pulses", 64'(ferr_pulse[0] - fp0), 64'd1);
    chk("abort frame_err cycles", 64'(ferr_cyc[0] - fc0), 64'd1);
    sb_check("abort");
    chk("abort rx_data held", rxd[0], 64'h1234_5678);
    cs_n[0] = 1'b0;
    exp_q.push_back('{8'd0, 64'h89AB_CDEF});
    word(0, 64'h89AB_CDEF, 32, 1'b0, r, f);
    wclk(4);
    cs_n[0] = 1'b1;
    wclk(10);
    sb_check("after abort");

    // reset pulse at bit 20 with CS held low
    cs_n[0] = 1'b0;
    word(0, 64'h0F0F_0F0F, 20, 1'b0, r, f);
    reset_n = 1'b0;
    wclk(1);
    chk("midreset rx_data", rxd[0], 64'd0);
    chk("midreset busy", 64'(busy[0]), 64'd0);
    chk("midreset miso_oe", 64'(oe[0]), 64'd0);
    chk("midreset miso", 64'(miso[0]), 64'd0);
    chk("midreset rx_valid", 64'(rxv[0]), 64'd0);
    chk("midreset tx_ack", 64'(ack[0]), 64'd0);
    chk("midreset frame_err", 64'(ferr[0]), 64'd0);
    reset_n = 1'b1;
    a0 = ack_cnt[0];
    word(0, 64'h0F0F_0F0F, 12, 1'b0, r, f);
    wclk(8);
    sb_check("post-reset sck ignored");
    chk("post-reset busy", 64'(busy[0]), 64'd0);
    chk("post-reset no load", 64'(ack_cnt[0] - a0), 64'd0);
    cs_n[0] = 1'b1;
    wclk(8);
    txd[0] = 64'h1357_9BDF;
    cs_n[0] = 1'b0;
    exp_q.push_back('{8'd0, 64'hCAFE_F00D});
    word(0, 64'hCAFE_F00D, 32, 1'b0, r, f);
    wclk(4);
    cs_n[0] = 1'b1;
    wclk(10);
    sb_check("post-reset frame");
    chk("post-reset master read", r, 64'h1357_9BDF);

    // 8-bit word; bit order follows the build
    txd[4] = 64'h80;
    cs_n[4] = 1'b0;
    exp_q.push_back('{8'd4, 64'h01});
    word(4, 64'h01, 8, 1'b0, r, f);
    wclk(4);
    cs_n[4] = 1'b1;
    wclk(10);
    sb_check("w8");
    chk("w8 master read", r, 64'h80);
    chk("w8 first bit", 64'(f), LSB ? 64'd0 : 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Parametrised successor to the sck-clocked SPI slave used for Raspberry Pi ↔ FPGA exchange.
- Runs entirely in the system clock domain. SCK, CS_n and MOSI are oversampled through synchronisers.
- Supports configurable word width and SPI mode (CPOL/CPHA), real chip-select framing, back-to-back words within one CS assertion, and abort detection.
- Sits between the GPIO_0_PI pins and the odometer/command register logic.

Parameters:
- WIDTH, 32: bits per word; legal range 8..64.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth on spi_sck, spi_cs_n and spi_mosi; legal range 2..3.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  synchronous, active-low reset.
- spi_sck  in  1  SPI clock from master (asynchronous).
- spi_cs_n  in  1  chip select, active low (asynchronous).
- spi_mosi  in  1  master-out data (asynchronous).
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable; top level drives pin = oe ? miso : 'z.
- tx_data  in  WIDTH  word to transmit; sampled at each word load.
- tx_ack  out  1  1-cycle pulse: tx_data was captured into the shifter.
- rx_data  out  WIDTH  last complete received word; held until the next word completes.
- rx_valid  out  1  1-cycle pulse: rx_data updated.
- frame_err  out  1  1-cycle pulse: CS deasserted mid-word.
- busy  out  1  high while CS is asserted (synchronised view).

Behaviour:
- Reset (reset_n=0 at a clk edge), all registers cleared:
  - spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_ack=0, frame_err=0, busy=0, bit_cnt=0.
  - Synchroniser SCK stages reset to CPOL; CS stages reset to 1; MOSI stages reset to 0.
- Synchronisation: SYNC_STAGES flops per input plus one history flop. Edges are detected by comparing the last stage with the history flop.
  - Leading edge = SCK leaves CPOL level. Trailing edge = SCK returns to CPOL level.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- Timing constraint: f_sck ≤ f_clk/8 (6.25 MHz at 50 MHz). Faster SCK is undefined.
- FSM states IDLE and ACTIVE:
  - IDLE→ACTIVE on synchronised CS falling edge. Same cycle: shifter ← tx_data, tx_ack=1, bit_cnt=0, busy=1, spi_miso_oe=1.
  - CPHA=0: spi_miso presents the MSB from the load cycle; each shift edge advances one bit.
  - CPHA=1: spi_miso holds the MSB from load; the first leading edge is not a shift; each later leading edge advances one bit.
  - Each sample edge: rx shifter ← {rx_shift[WIDTH-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches WIDTH on a sample edge, the next cycle does all of the following:
    - rx_data ← shifter and rx_valid=1;
    - bit_cnt ← 0;
    - shifter reloaded from tx_data with tx_ack=1, so back-to-back words need no CS toggle.
  - ACTIVE→IDLE on synchronised CS rising edge: busy=0, spi_miso_oe=0.
    - bit_cnt≠0: frame_err=1 for 1 cycle; partial word discarded; rx_data unchanged; no rx_valid.
    - bit_cnt=0: clean end; no pulse.
- Simultaneous events:
  - CS rise in the same cycle as the final sample edge: word completes (rx_valid=1), no frame_err.
  - SCK edges seen while IDLE are ignored.
- Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the pin-level final sample edge (4 at default).
- rx_data is never partially updated.
- Reset mid-frame: return to IDLE; a new word starts only after a fresh CS falling edge. A CS already low when reset releases is ignored until it goes high and falls again.
- tx_data is sampled only on load cycles. Changes at other times have no effect on the current word.

Optional Feature:
- Macro SPI_SLAVE_LSB_FIRST_EN.
- Defined: both directions are LSB-first. spi_miso presents tx bit 0 first; received bits shift in from the MSB side (rx_shift ← {mosi, rx_shift[WIDTH-1:1]}).
- Undefined: MSB-first as described above.
- Timing, handshakes and counts are identical in both builds.

Test Plan:
- Mode 0, WIDTH=32, tx_data=0xA5A5_0F0F; master sends 0x1234_5678 at clk/8 → rx_valid once, rx_data=0x1234_5678; master reads 0xA5A5_0F0F; tx_ack once at CS fall.
- Modes 1, 2 and 3 (CPOL/CPHA swept), WIDTH=16, master sends 0xBEEF with tx_data=0x5AA5 → rx_data=0xBEEF and master reads 0x5AA5 in every mode.
- One CS assertion, three words 0x1, 0x2, 0x3; tx_data changed after each tx_ack to 0x10, 0x20, 0x30 → three rx_valid pulses with rx_data in order; master reads 0x10, 0x20, 0x30; exactly three tx_ack pulses.
- CS raised after 13 of 32 bits → frame_err exactly one cycle; rx_valid never asserted; rx_data keeps its previous value 0x1234_5678; next full frame received correctly.
- reset_n=0 for 1 cycle at bit 20 with CS held low → all outputs 0; further SCK edges ignored; after CS high then low, 0xCAFE_F00D received correctly.
- SPI_SLAVE_LSB_FIRST_EN build, WIDTH=8: master shifts 0x01 LSB-first and reads tx_data=0x80 → rx_data=0x01; master observes bits 0,0,0,0,0,0,0,1 in order.
